multicycle_ctrl: RTL and testbench

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

---
 rtl/multicycle_ctrl_pkg.sv | 58 +++++
 rtl/ctrl_decode.sv | 66 ++++++
 rtl/multicycle_ctrl.sv | 106 ++++++++++
 tb/tb_multicycle_ctrl.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/multicycle_ctrl_pkg.sv
// Shared definitions for the multicycle controller: state encodings, opcodes,
// ALU-control classes and the decoded control bundle.
package multicycle_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_RCOMP  = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_B      = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMMSH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic [1:0] alu_op;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic       pc_write;
        logic       pc_write_cond;
        logic       ir_write;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic       iord;
        logic       mem_to_reg;
        logic       reg_dst;
        logic [1:0] pc_source;
    } ctrl_t;

    function automatic logic is_legal_op(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
               (op == OP_BEQ) || (op == OP_J);
    endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Moore output decode: maps the current state to the raw control bundle.
// FETCH strobes are qualified with memReady by the parent.
module ctrl_decode
    import multicycle_ctrl_pkg::*;
(
    input  state_t state,
    output ctrl_t  ctrl
);

    always_comb begin
        ctrl = '0;
        case (state)
            S_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.alu_op    = ALUOP_ADD;
                ctrl.pc_source = PCSRC_ALU;
                ctrl.ir_write  = 1'b1;
                ctrl.pc_write  = 1'b1;
            end
            S_DECODE: begin
                ctrl.alu_src_b = SRCB_IMMSH2;
                ctrl.alu_op    = ALUOP_ADD;
            end
            S_MEMADR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_ADD;
            end
            S_MEMRD: begin
                ctrl.mem_read = 1'b1;
                ctrl.iord     = 1'b1;
            end
            S_MEMWR: begin
                ctrl.mem_write = 1'b1;
                ctrl.iord      = 1'b1;
            end
            S_MEMWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
            end
            S_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_B;
                ctrl.alu_op    = ALUOP_FUNCT;
            end
            S_RCOMP: begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_src_b     = SRCB_B;
                ctrl.alu_op        = ALUOP_SUB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_source     = PCSRC_ALUOUT;
            end
            S_JUMP: begin
                ctrl.pc_write  = 1'b1;
                ctrl.pc_source = PCSRC_JUMP;
            end
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS-style control unit: sequencing FSM, latched opcode,
// retired-instruction counter and reset-gated datapath strobes.
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       opCode,
    input  logic             memReady,
    output logic [1:0]       aluOp,
    output logic             aluSrcA,
    output logic [1:0]       aluSrcB,
    output logic             pcWrite,
    output logic             pcWriteCond,
    output logic             irWrite,
    output logic             memRead,
    output logic             memWrite,
    output logic             regWrite,
    output logic             iorD,
    output logic             memtoReg,
    output logic             regDst,
    output logic [1:0]       pcSource,
    output logic             illegalOp,
    output logic [3:0]       state,
    output logic [CNT_W-1:0] retired
);

    state_t           state_reg;
    logic [5:0]       opcode_reg;
    logic [CNT_W-1:0] retired_reg;
    ctrl_t            ctrl;
    logic             in_fetch;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg   <= S_FETCH;
            opcode_reg  <= '0;
            retired_reg <= '0;
        end else begin
            case (state_reg)
                S_FETCH: begin
                    if (memReady) state_reg <= S_DECODE;
                end
                S_DECODE: begin
                    opcode_reg <= opCode;
                    case (opCode)
                        OP_RTYPE:    state_reg <= S_EXEC;
                        OP_LW, OP_SW: state_reg <= S_MEMADR;
                        OP_BEQ:      state_reg <= S_BRANCH;
                        OP_J:        state_reg <= S_JUMP;
                        default:     state_reg <= S_FETCH;
                    endcase
                end
                S_MEMADR: begin
                    if (opcode_reg == OP_LW)      state_reg <= S_MEMRD;
                    else if (opcode_reg == OP_SW) state_reg <= S_MEMWR;
                    else                          state_reg <= S_FETCH;
                end
                S_MEMRD: begin
                    if (memReady) state_reg <= S_MEMWB;
                end
                S_MEMWR: begin
                    if (memReady) begin
                        state_reg   <= S_FETCH;
                        retired_reg <= retired_reg + CNT_W'(1);
                    end
                end
                S_EXEC: state_reg <= S_RCOMP;
                S_MEMWB, S_RCOMP, S_BRANCH, S_JUMP: begin
                    state_reg   <= S_FETCH;
                    retired_reg <= retired_reg + CNT_W'(1);
                end
                default: state_reg <= S_FETCH;
            endcase
        end
    end

    ctrl_decode u_decode (
        .state (state_reg),
        .ctrl  (ctrl)
    );

    assign in_fetch = (state_reg == S_FETCH);

    // In FETCH the IR/PC load only when the memory read actually completes.
    assign irWrite     = ctrl.ir_write & memReady & ~reset;
    assign pcWrite     = ctrl.pc_write & (~in_fetch | memReady) & ~reset;
    assign pcWriteCond = ctrl.pc_write_cond & ~reset;
    assign memWrite    = ctrl.mem_write & ~reset;
    assign regWrite    = ctrl.reg_write & ~reset;
    assign illegalOp   = (state_reg == S_DECODE) & ~is_legal_op(opCode) & ~reset;

    assign aluOp    = ctrl.alu_op;
    assign aluSrcA  = ctrl.alu_src_a;
    assign aluSrcB  = ctrl.alu_src_b;
    assign memRead  = ctrl.mem_read;
    assign iorD     = ctrl.iord;
    assign memtoReg = ctrl.mem_to_reg;
    assign regDst   = ctrl.reg_dst;
    assign pcSource = ctrl.pc_source;
    assign state    = state_reg;
    assign retired  = retired_reg;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl with a 4-bit retired counter so the
// wrap case fits in a short run.
module tb_multicycle_ctrl;

    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic [5:0]       opCode;
    logic             memReady;
    logic [1:0]       aluOp;
    logic             aluSrcA;
    logic [1:0]       aluSrcB;
    logic             pcWrite, pcWriteCond, irWrite, memRead, memWrite, regWrite;
    logic             iorD, memtoReg, regDst;
    logic [1:0]       pcSource;
    logic             illegalOp;
    logic [3:0]       state;
    logic [CNT_W-1:0] retired;

    int vectors = 0;
    int miscompares = 0;

    multicycle_ctrl #(.CNT_W(CNT_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .opCode      (opCode),
        .memReady    (memReady),
        .aluOp       (aluOp),
        .aluSrcA     (aluSrcA),
        .aluSrcB     (aluSrcB),
        .pcWrite     (pcWrite),
        .pcWriteCond (pcWriteCond),
        .irWrite     (irWrite),
        .memRead     (memRead),
        .memWrite    (memWrite),
        .regWrite    (regWrite),
        .iorD        (iorD),
        .memtoReg    (memtoReg),
        .regDst      (regDst),
        .pcSource    (pcSource),
        .illegalOp   (illegalOp),
        .state       (state),
        .retired     (retired)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end else begin
            $display("ok   %s: %0h", tag, obs);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset    = 1'b1;
        memReady = 1'b1;
        opCode   = 6'b000000;
        tick();
        tick();
        check("rst_state",   32'(state), 32'd0);
        check("rst_retired", 32'(retired), 32'd0);
        check("rst_irWrite", 32'(irWrite), 32'd0);
        check("rst_pcWrite", 32'(pcWrite), 32'd0);

        @(negedge clk);
        reset = 1'b0;
        #1;
        check("fetch_irWrite", 32'(irWrite), 32'd1);
        check("fetch_pcWrite", 32'(pcWrite), 32'd1);
        check("fetch_memRead", 32'(memRead), 32'd1);
        check("fetch_aluSrcB", 32'(aluSrcB), 32'd1);

        // lw: 0,1,2,3,4,0
        opCode = 6'b100011;
        check("lw_s0", 32'(state), 32'd0);
        tick();
        check("lw_s1", 32'(state), 32'd1);
        check("lw_dec_aluSrcB", 32'(aluSrcB), 32'd3);
        check("lw_dec_regWrite", 32'(regWrite), 32'd0);
        tick();
        check("lw_s2", 32'(state), 32'd2);
        check("lw_adr_srcA", 32'(aluSrcA), 32'd1);
        check("lw_adr_srcB", 32'(aluSrcB), 32'd2);
        tick();
        check("lw_s3", 32'(state), 32'd3);
        check("lw_rd_iorD", 32'(iorD), 32'd1);
        check("lw_rd_regWrite", 32'(regWrite), 32'd0);
        tick();
        check("lw_s4", 32'(state), 32'd4);
        check("lw_wb_regWrite", 32'(regWrite), 32'd1);
        check("lw_wb_memtoReg", 32'(memtoReg), 32'd1);
        tick();
        check("lw_s0_end", 32'(state), 32'd0);
        check("lw_retired", 32'(retired), 32'd1);
        check("lw_fetch_regWrite", 32'(regWrite), 32'd0);

        // fetch stall for three cycles
        memReady = 1'b0;
        opCode   = 6'b111111;
        #1;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("stall%0d_irWrite", i), 32'(irWrite), 32'd0);
            check($sformatf("stall%0d_pcWrite", i), 32'(pcWrite), 32'd0);
            tick();
            check($sformatf("stall%0d_state", i), 32'(state), 32'd0);
        end
        memReady = 1'b1;
        #1;
        check("stall_release_irWrite", 32'(irWrite), 32'd1);

        // illegal opcode
        tick();
        check("ill_state", 32'(state), 32'd1);
        check("ill_pulse", 32'(illegalOp), 32'd1);
        check("ill_irWrite", 32'(irWrite), 32'd0);
        tick();
        check("ill_next_state", 32'(state), 32'd0);
        check("ill_pulse_end", 32'(illegalOp), 32'd0);
        check("ill_retired", 32'(retired), 32'd1);

        // R-type then beq
        opCode = 6'b000000;
        check("r_fetch_aluOp", 32'(aluOp), 32'd0);
        tick();
        check("r_dec_aluOp", 32'(aluOp), 32'd0);
        tick();
        check("r_exec_state", 32'(state), 32'd6);
        check("r_exec_aluOp", 32'(aluOp), 32'd2);
        check("r_exec_srcB", 32'(aluSrcB), 32'd0);
        tick();
        check("r_rcomp_state", 32'(state), 32'd7);
        check("r_rcomp_regDst", 32'(regDst), 32'd1);
        check("r_rcomp_regWrite", 32'(regWrite), 32'd1);
        tick();
        check("r_done_state", 32'(state), 32'd0);
        opCode = 6'b000100;
        tick();
        check("beq_dec_aluOp", 32'(aluOp), 32'd0);
        tick();
        check("beq_state", 32'(state), 32'd8);
        check("beq_aluOp", 32'(aluOp), 32'd1);
        check("beq_pcWriteCond", 32'(pcWriteCond), 32'd1);
        check("beq_pcSource", 32'(pcSource), 32'd1);
        check("beq_pcWrite", 32'(pcWrite), 32'd0);
        tick();
        check("beq_done_state", 32'(state), 32'd0);
        check("rbeq_retired", 32'(retired), 32'd3);

        // sw interrupted by reset while memory is stalled
        opCode = 6'b101011;
        tick();
        tick();
        check("sw_adr_state", 32'(state), 32'd2);
        tick();
        check("sw_wr_state", 32'(state), 32'd5);
        check("sw_wr_memWrite", 32'(memWrite), 32'd1);
        memReady = 1'b0;
        tick();
        check("sw_stall_state", 32'(state), 32'd5);
        check("sw_stall_memWrite", 32'(memWrite), 32'd1);
        reset = 1'b1;
        #1;
        check("rst_mid_memWrite", 32'(memWrite), 32'd0);
        check("rst_mid_state", 32'(state), 32'd0);
        check("rst_mid_retired", 32'(retired), 32'd0);
        tick();
        memReady = 1'b1;
        opCode   = 6'b000010;
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst_resume_state", 32'(state), 32'd0);

        // 16 jumps wrap the 4-bit counter
        for (int k = 0; k < 16; k++) begin
            tick();
            tick();
            if (k == 0) begin
                check("j_state", 32'(state), 32'd9);
                check("j_pcWrite", 32'(pcWrite), 32'd1);
                check("j_pcSource", 32'(pcSource), 32'd2);
            end
            tick();
            if (k == 14) check("j_retired_15", 32'(retired), 32'd15);
        end
        check("j_wrap_retired", 32'(retired), 32'd0);
        check("j_wrap_state", 32'(state), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
